fir_seq_ctrl: RTL and testbench
===============================

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameter A_WIDTH, default 13: width of sample address and frame length.
REQ-002 Parameter ROM_LAT, default 1: cycles from rom_raddr issue to valid xn_data at the filter input.
REQ-003 Parameter FIR_LAT, default 5: cycles from xn_data presented to the filter until the corresponding yn_data is valid.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle frame start request.
REQ-007 abort  in  1  terminate the current frame.
REQ-008 cfg_len  in  A_WIDTH  samples per frame; max 5000; sampled on accepted start.
REQ-009 rom_ren  out  1  sample ROM read enable.
REQ-010 rom_raddr  out  A_WIDTH  sample ROM read address.
REQ-011 fir_start  out  1  one-cycle pulse to the filter, coincident with the first rom_ren.
REQ-012 yn_data  in  8  signed filter output.
REQ-013 wr_en / wr_addr / wr_data  out  1 / A_WIDTH / 8  result RAM write port.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse on normal frame completion.
REQ-016 sat_cnt  out  A_WIDTH  count of saturated outputs in the last frame.

Function
REQ-017 States: IDLE, RUN, DRAIN, DONE; encoding per shared package.
REQ-018 IDLE->RUN on start=1; cfg_len captured into len_r; rom_raddr starts at 0.
REQ-019 In RUN: rom_ren=1 every cycle; rom_raddr increments 0..len_r-1; RUN->DRAIN after the cycle issuing address len_r-1.
REQ-020 Read valid is delayed ROM_LAT+FIR_LAT cycles; each delayed valid asserts wr_en with wr_data=yn_data.
REQ-021 wr_addr starts at 0 and increments by one per write; exactly len_r writes per frame.
REQ-022 DRAIN->DONE in the cycle after the last write; DONE lasts 1 cycle with done=1, then goes to IDLE.
REQ-023 start while busy=1 is ignored; cfg_len changes mid-frame have no effect.
REQ-024 cfg_len=0: IDLE->DONE directly; no rom_ren, no fir_start, no wr_en; done pulses 1 cycle after start.
REQ-025 abort=1 in RUN or DRAIN: next state IDLE.
REQ-026 abort also flushes the delay line so that wr_en=0 from the next cycle.
REQ-027 After abort, done never pulses for that frame.
REQ-028 abort in IDLE or DONE has no effect.
REQ-029 start and abort asserted together in IDLE: start wins.
REQ-030 Address counters do not wrap; cfg_len>5000 is clamped to 5000.

Reset
REQ-031 rst=1 from any state sets: state IDLE, all counters 0, delay line cleared, sat_cnt 0, every output 0 on the next edge.
REQ-032 rst takes priority over start and abort; a frame interrupted by reset produces no further writes or done.

Configuration
REQ-033 FIR_SEQ_SAT_CNT_EN defined: sat_cnt clears on accepted start and increments on each write where wr_data is 8'h7f or 8'h80.
REQ-034 With FIR_SEQ_SAT_CNT_EN defined, sat_cnt holds its value from DONE until the next start.
REQ-035 FIR_SEQ_SAT_CNT_EN undefined: sat_cnt is tied to 0 and no counter logic is synthesised.

Structure
REQ-036 Package fir_seq_pkg holds: the state enum; constants MAX_LEN=5000, default ROM_LAT and FIR_LAT, SAT_POS=8'h7f, SAT_NEG=8'h80.
REQ-037 Sub-module fir_valid_dly: parameterised-depth valid shift register with synchronous clear, used for the read-to-write alignment.

Verification
REQ-038 cfg_len=8, start pulse -> fir_start with rom_raddr=0; 8 wr_en cycles beginning 6 cycles after the first rom_ren, wr_addr 0..7; done 1 cycle after the last write.
REQ-039 cfg_len=0, start -> no rom_ren/wr_en; done=1 on the following cycle; busy=1 for that cycle only.
REQ-040 cfg_len=20, abort at the 5th RUN cycle -> state IDLE next cycle, wr_en=0 thereafter, no done.
REQ-041 Second start during RUN and cfg_len changed mid-frame -> ignored; exactly the originally captured count of writes.
REQ-042 yn_data forced to 8'h7f ×3 and 8'h80 ×2 in a 10-sample frame -> sat_cnt=5 with the macro defined, 0 without it.
REQ-043 rst=1 mid-DRAIN -> all outputs 0 next cycle; a following start with cfg_len=4 runs a clean frame.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared states, limits and saturation codes for the FIR sequencer
package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          MAX_LEN     = 5000;
  localparam int          DEF_ROM_LAT = 1;
  localparam int          DEF_FIR_LAT = 5;
  localparam logic [7:0]  SAT_POS     = 8'h7f;
  localparam logic [7:0]  SAT_NEG     = 8'h80;

  function automatic logic is_sat(input logic [7:0] v);
    return (v == SAT_POS) || (v == SAT_NEG);
  endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// rtl/fir_seq_ctrl_if.sv - control, ROM, filter and result-RAM signals of the FIR sequencer
interface fir_seq_ctrl_if #(
  parameter int A_WIDTH = 13
);
  logic               start;
  logic               abort;
  logic [A_WIDTH-1:0] cfg_len;
  logic               rom_ren;
  logic [A_WIDTH-1:0] rom_raddr;
  logic               fir_start;
  logic [7:0]         yn_data;
  logic               wr_en;
  logic [A_WIDTH-1:0] wr_addr;
  logic [7:0]         wr_data;
  logic               busy;
  logic               done;
  logic [A_WIDTH-1:0] sat_cnt;

  modport master (
    output start, abort, cfg_len, yn_data,
    input  rom_ren, rom_raddr, fir_start, wr_en, wr_addr, wr_data, busy, done, sat_cnt
  );

  modport slave (
    input  start, abort, cfg_len, yn_data,
    output rom_ren, rom_raddr, fir_start, wr_en, wr_addr, wr_data, busy, done, sat_cnt
  );
endinterface

// File: rtl/fir_seq_ctrl_valid_dly.sv
// rtl/fir_seq_ctrl_valid_dly.sv - fir_valid_dly: valid shift register aligning ROM reads to filter outputs
module fir_valid_dly #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (clr) sr <= '0;
    else     sr <= (sr << 1) | DEPTH'(din);
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - FIR frame sequencer: ROM read issue, delayed result write, done/abort control
// FIR_SEQ_SAT_CNT_EN enables the per-frame saturated-output counter.
module fir_seq_ctrl
  import fir_seq_pkg::*;
#(
  parameter int A_WIDTH = 13,
  parameter int ROM_LAT = DEF_ROM_LAT,
  parameter int FIR_LAT = DEF_FIR_LAT
) (
  input  logic           clk,
  input  logic           rst,
  fir_seq_ctrl_if.slave  bus
);
  localparam int                 DLY       = ROM_LAT + FIR_LAT;
  localparam logic [A_WIDTH-1:0] MAX_LEN_A = A_WIDTH'(MAX_LEN);

  state_t             state;
  logic [A_WIDTH-1:0] len_r;
  logic [A_WIDTH-1:0] raddr;
  logic [A_WIDTH-1:0] waddr;
  logic               ren;
  logic               fstart;
  logic               busy_r;
  logic               done_r;
  logic               wen;
  logic [A_WIDTH-1:0] start_len;
  logic               flush;

  assign start_len = (bus.cfg_len > MAX_LEN_A) ? MAX_LEN_A : bus.cfg_len;
  // Aborting kills every read still in flight so no stale write escapes.
  assign flush = rst | (bus.abort & ((state == RUN) | (state == DRAIN)));

  fir_valid_dly #(.DEPTH(DLY)) u_dly (
    .clk  (clk),
    .clr  (flush),
    .din  (ren),
    .dout (wen)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      len_r  <= '0;
      raddr  <= '0;
      waddr  <= '0;
      ren    <= 1'b0;
      fstart <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      fstart <= 1'b0;
      if (wen) waddr <= waddr + 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          len_r  <= start_len;
          raddr  <= '0;
          waddr  <= '0;
          busy_r <= 1'b1;
          if (start_len == '0) begin
            state  <= DONE;
            done_r <= 1'b1;
          end else begin
            state  <= RUN;
            ren    <= 1'b1;
            fstart <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state  <= IDLE;
            ren    <= 1'b0;
            raddr  <= '0;
            busy_r <= 1'b0;
          end else if (raddr == len_r - 1'b1) begin
            state <= DRAIN;
            ren   <= 1'b0;
            raddr <= '0;
          end else begin
            raddr <= raddr + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (wen && (waddr == len_r - 1'b1)) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIR_SEQ_SAT_CNT_EN
  logic [A_WIDTH-1:0] sat_r;

  always_ff @(posedge clk) begin
    if (rst)                              sat_r <= '0;
    else if ((state == IDLE) && bus.start) sat_r <= '0;
    else if (wen && is_sat(bus.yn_data))   sat_r <= sat_r + 1'b1;
  end

  assign bus.sat_cnt = sat_r;
`else
  assign bus.sat_cnt = '0;
`endif

  assign bus.rom_ren   = ren;
  assign bus.rom_raddr = raddr;
  assign bus.fir_start = fstart;
  assign bus.wr_en     = wen;
  assign bus.wr_addr   = waddr;
  assign bus.wr_data   = wen ? bus.yn_data : 8'h00;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - randomized bench for fir_seq_ctrl against a frame-timeline reference model
module tb_fir_seq_ctrl;
  localparam int AW = 13;
  localparam int D  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.A_WIDTH(AW)) bus();

  fir_seq_ctrl #(.A_WIDTH(AW), .ROM_LAT(1), .FIR_LAT(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;

  // Frame model: a frame is its accept edge and length; every output is a
  // function of how many cycles have elapsed since acceptance.
  bit m_active = 0;
  int m_t0 = 0;
  int m_len = 0;
  int m_sat = 0;
  int m_pend = 0;
  bit m_rst_prev = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at edge %0d", tag, got, exp, n);
    end
  endtask

  function automatic int last_c(input int len);
    return (len == 0) ? 0 : len + D;
  endfunction

  function automatic int clamp(input int len);
    return (len > 5000) ? 5000 : len;
  endfunction

  task automatic model_edge();
    int cp;
    bit prev_busy;
    n++;
    cp = n - 1 - m_t0;
    prev_busy = m_active && (cp <= last_c(m_len));
    if (rst) begin
      m_active = 0;
      m_sat = 0;
    end else begin
`ifdef FIR_SEQ_SAT_CNT_EN
      m_sat += m_pend;
`endif
      if (!prev_busy) begin
        m_active = 0;
        if (bus.start) begin
          m_active = 1;
          m_t0 = n;
          m_len = clamp(int'(bus.cfg_len));
          m_sat = 0;
        end
      end else if (bus.abort && m_len > 0 && cp <= m_len + D - 1) begin
        m_active = 0;
      end
    end
    m_rst_prev = rst;
    m_pend = 0;
  endtask

  task automatic check_outputs();
    int c;
    bit act, e_ren, e_wen;
    c = n - m_t0;
    act = m_active && (c <= last_c(m_len));
    e_ren = act && m_len > 0 && c < m_len;
    e_wen = act && m_len > 0 && c >= D && c <= m_len - 1 + D;
    check("rom_ren", 32'(bus.rom_ren), 32'(e_ren));
    check("fir_start", 32'(bus.fir_start), 32'(act && m_len > 0 && c == 0));
    check("wr_en", 32'(bus.wr_en), 32'(e_wen));
    check("busy", 32'(bus.busy), 32'(act));
    check("done", 32'(bus.done), 32'(act && c == last_c(m_len)));
    check("sat_cnt", 32'(bus.sat_cnt), 32'(m_sat));
    if (e_ren) check("rom_raddr", 32'(bus.rom_raddr), 32'(c));
    if (e_wen) begin
      check("wr_addr", 32'(bus.wr_addr), 32'(c - D));
      check("wr_data", 32'(bus.wr_data), 32'(bus.yn_data));
      if (bus.yn_data == 8'h7f || bus.yn_data == 8'h80) m_pend = 1;
    end
    if (m_rst_prev) begin
      check("rst_raddr", 32'(bus.rom_raddr), 32'd0);
      check("rst_waddr", 32'(bus.wr_addr), 32'd0);
      check("rst_wdata", 32'(bus.wr_data), 32'd0);
    end
  endtask

  function automatic logic [7:0] rand_yn();
    case ($urandom_range(0, 7))
      0:       return 8'h7f;
      1:       return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic step(input logic s, input logic a, input logic [AW-1:0] len, input logic r);
    bus.start = s;
    bus.abort = a;
    bus.cfg_len = len;
    rst = r;
    @(posedge clk);
    model_edge();
    #1;
    bus.yn_data = rand_yn();
    #1;
    check_outputs();
  endtask

  task automatic idle_wait(input int max_cyc);
    int k = 0;
    while (m_active && k < max_cyc) begin
      step(1'b0, 1'b0, AW'($urandom), 1'b0);
      k++;
    end
    check("idle_bound", 32'(m_active), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    bus.start = 0;
    bus.abort = 0;
    bus.cfg_len = '0;
    bus.yn_data = '0;
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    step(1'b1, 1'b0, 13'd8, 1'b0);
    idle_wait(100);

    step(1'b1, 1'b0, 13'd0, 1'b0);
    idle_wait(10);

    step(1'b1, 1'b0, 13'd20, 1'b0);
    repeat (4) step(1'b0, 1'b0, 13'd3, 1'b0);
    step(1'b0, 1'b1, 13'd3, 1'b0);
    repeat (30) step(1'b0, 1'b0, 13'd3, 1'b0);

    step(1'b1, 1'b0, 13'd12, 1'b0);
    repeat (10) step(1'b1, 1'b0, AW'($urandom_range(1, 40)), 1'b0);
    idle_wait(100);

    step(1'b1, 1'b0, 13'd10, 1'b0);
    idle_wait(100);

    step(1'b1, 1'b0, 13'd10, 1'b0);
    repeat (12) step(1'b0, 1'b0, 13'd10, 1'b0);
    step(1'b0, 1'b0, 13'd10, 1'b1);
    repeat (8) step(1'b0, 1'b0, 13'd10, 1'b0);
    step(1'b1, 1'b0, 13'd4, 1'b0);
    idle_wait(100);

    step(1'b1, 1'b1, 13'd3, 1'b0);
    idle_wait(100);

    step(1'b1, 1'b0, 13'd8191, 1'b0);
    idle_wait(5100);

    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(0, 40);
      int life = $urandom_range(0, 60);
      step(1'b1, 1'b0, AW'(len), 1'b0);
      for (int k = 0; k < life && m_active; k++)
        step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0),
             AW'($urandom), 1'($urandom_range(0, 150) == 0));
      idle_wait(100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
